bram_burst_reader: RTL
======================

Name: bram_burst_reader

Overview:
- Burst-read master for one port of the team's 2-bit-wide, 2048-deep dual-port block RAM.
- On a start command it drives the port's enable and address for a run of consecutive words, absorbing the RAM's 1-cycle registered-read latency.
- Returned words are delivered on a valid/ready stream with full backpressure, so PicoBlaze-side or peripheral logic can consume RAM contents at 1 word/cycle.
- It is the consumer end of the RAM write path.

Parameters:
- ADDR_W, 11, RAM word-address width; depth = 2**ADDR_W.
- DATA_W, 2, RAM word width.

Ports:
- CLKA  input  1  block clock; also clocks the RAM port driven by this block.
- RSTB  input  1  reset, synchronous, active-high.
- start  input  1  1-cycle command strobe; sampled only in IDLE.
- start_addr  input  ADDR_W  first word address, captured with start.
- length  input  ADDR_W+1  word count, 0..2**ADDR_W, captured with start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  1-cycle pulse at burst completion.
- ram_en  output  1  RAM port enable.
- ram_we  output  1  RAM port write enable, constant 0.
- ram_rst  output  1  RAM port output reset, constant 0.
- ram_addr  output  ADDR_W  RAM port address.
- ram_do  input  DATA_W  RAM port read data, valid 1 cycle after ram_en.
- m_valid  output  1  stream data valid.
- m_ready  input  1  stream consumer ready.
- m_data  output  DATA_W  stream word.
- m_last  output  1  marks the final word of the burst.

Behaviour:
- Reset (RSTB=1 at a CLKA edge), including mid-burst:
  - State returns to IDLE and the skid FIFO and in-flight flag are cleared.
  - busy, done, ram_en, m_valid, m_last = 0; ram_addr = 0; m_data = 0.
  - Words already read are discarded. Reset has priority over every other input.
- State machine IDLE/RUN/DRAIN:
  - IDLE:
    - start=1 with length>0: capture start_addr and length into addr_q and remain_q, then go to RUN.
    - start=1 with length=0: done pulses on the next cycle, busy stays 0, ram_en is never asserted, state stays IDLE.
  - RUN:
    - A read is issued (ram_en=1, ram_addr=addr_q) in any cycle where remain_q>0 and credit is available.
    - Credit is available when fifo_cnt + inflight < 2, or when a stream pop (m_valid & m_ready) happens in the same cycle.
    - On each issue: addr_q increments modulo 2**ADDR_W (0x7FF wraps to 0x000) and remain_q decrements.
    - When the last read is issued, go to DRAIN.
  - DRAIN: no new reads. After the final word (m_last=1) is popped, go to IDLE, done=1 for one cycle, and busy falls in that same cycle.
- inflight:
  - Set in the cycle after a read is issued; ram_do is pushed into the FIFO in that cycle.
  - The FIFO never overflows, by construction of the credit rule.
- Stream rules:
  - m_data and m_last are held stable while m_valid=1 and m_ready=0.
  - No word is lost or duplicated.
  - m_last is tagged on the word from the final issued address.
- Timing and throughput:
  - start accepted at edge N: first ram_en at cycle N+1, earliest m_valid at cycle N+2.
  - With m_ready held at 1, one word per cycle.
  - For length L, done asserts at cycle N+L+2.
- A start while busy=1 is ignored.

Optional Feature:
- Macro: BRAM_READER_PARITY_EN.
- Defined:
  - Adds output port m_parity (1 bit) = XOR of m_data bits.
  - m_parity is computed at FIFO push, stored alongside the data, and stable under backpressure.
  - Reset value 0.
- Undefined: port and storage are absent; all other behaviour is identical.

Decomposition:
- Package bram_reader_pkg:
  - State enum (IDLE, RUN, DRAIN).
  - Default ADDR_W/DATA_W constants.
  - FIFO depth constant = 2.
- Sub-module bram_reader_skid:
  - 2-entry FIFO of {last, [parity], data}.
  - push/pop ports and a count output used by the credit logic.

Test Plan:
- Preload mem[a] = a[1:0]; start_addr=0x010, length=4, m_ready=1 -> m_data 0,1,2,3 on consecutive cycles; m_last on the 4th word; first m_valid at start+2; done at start+6.
- start_addr=0x7FE, length=4 -> ram_addr sequence 0x7FE, 0x7FF, 0x000, 0x001; data 2,3,0,1.
- length=8 with m_ready pattern 1,0,0,1,0,1,1,... -> exact ordered data, no drops or duplicates; ram_en low whenever fifo_cnt + inflight = 2 and there is no pop.
- length=0 -> done pulse next cycle; busy, ram_en, m_valid stay 0.
- RSTB pulsed after 3 of 8 words -> all outputs 0 next cycle; a new start (addr 0x100, length 2) then runs cleanly.
- start re-pulsed mid-burst with different addr/length -> ignored; original burst completes unchanged.

Source files
------------

// File: rtl/bram_reader_pkg.sv
// Shared types and constants for the block-RAM burst reader.
// The m_parity feature is enabled by defining BRAM_READER_PARITY_EN.
package bram_reader_pkg;

  localparam int unsigned DEF_ADDR_W = 11;
  localparam int unsigned DEF_DATA_W = 2;
  localparam int unsigned FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  function automatic logic parity_of(input logic [31:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/bram_burst_reader_if.sv
// Valid/ready read-data stream of the burst reader.
// Carries m_parity only when BRAM_READER_PARITY_EN is defined.
interface bram_burst_reader_if #(
  parameter int DATA_W = 2
);
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
`ifdef BRAM_READER_PARITY_EN
  logic              m_parity;

  modport master (output m_valid, m_data, m_last, m_parity, input m_ready);
  modport slave  (input m_valid, m_data, m_last, m_parity, output m_ready);
`else
  modport master (output m_valid, m_data, m_last, input m_ready);
  modport slave  (input m_valid, m_data, m_last, output m_ready);
`endif
endinterface

// File: rtl/bram_reader_skid.sv
// Two-entry FIFO absorbing words already requested from the RAM when the
// stream consumer stalls; its count feeds the reader's read-credit logic.
module bram_reader_skid
  import bram_reader_pkg::*;
#(
  parameter int ENTRY_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [ENTRY_W-1:0] push_data,
  output logic [ENTRY_W-1:0] head,
  output logic [1:0]         cnt
);

  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [ENTRY_W-1:0] mem_d [FIFO_DEPTH];
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [1:0]         cnt_q, cnt_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= {ENTRY_W{1'b0}};
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head = mem_q[rd_ptr_q];
  assign cnt  = cnt_q;

endmodule

// File: rtl/bram_burst_reader.sv
// Burst-read master for one block-RAM port, streaming words out on valid/ready.
// Define BRAM_READER_PARITY_EN to add m_parity (XOR of m_data) to the stream.
module bram_burst_reader
  import bram_reader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              CLKA,
  input  logic              RSTB,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic              ram_en,
  output logic              ram_we,
  output logic              ram_rst,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_do,
  bram_burst_reader_if.master m
);

`ifdef BRAM_READER_PARITY_EN
  localparam int ENTRY_W = DATA_W + 2;
`else
  localparam int ENTRY_W = DATA_W + 1;
`endif

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     remain_q, remain_d;
  logic                inflight_q, inflight_d;
  logic                inflight_last_q, inflight_last_d;
  logic                done_q, done_d;

  logic [ENTRY_W-1:0]  push_data;
  logic [ENTRY_W-1:0]  head;
  logic [1:0]          fifo_cnt;
  logic                pop;
  logic                credit;
  logic                issue;
  logic                final_issue;

  assign pop         = (fifo_cnt != 2'd0) && m.m_ready;
  // A same-cycle pop frees a slot, so a full pipeline can still issue.
  assign credit      = (({1'b0, fifo_cnt} + {2'b00, inflight_q}) < 3'd2) || pop;
  assign issue       = (state_q == RUN) && (remain_q != (ADDR_W+1)'(0)) && credit;
  assign final_issue = issue && (remain_q == (ADDR_W+1)'(1));

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    remain_d        = remain_q;
    done_d          = 1'b0;
    inflight_d      = issue;
    inflight_last_d = final_issue;
    case (state_q)
      IDLE: begin
        if (start && (length != (ADDR_W+1)'(0))) begin
          addr_d   = start_addr;
          remain_d = length;
          state_d  = RUN;
        end else if (start) begin
          done_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (issue) begin
          addr_d   = addr_q + ADDR_W'(1);
          remain_d = remain_q - (ADDR_W+1)'(1);
          state_d  = final_issue ? DRAIN : RUN;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (pop && head[ENTRY_W-1]) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLKA) begin
    if (RSTB) begin
      state_q         <= IDLE;
      addr_q          <= {ADDR_W{1'b0}};
      remain_q        <= {(ADDR_W+1){1'b0}};
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remain_q        <= remain_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      done_q          <= done_d;
    end
  end

`ifdef BRAM_READER_PARITY_EN
  assign push_data  = {inflight_last_q, parity_of(32'(ram_do)), ram_do};
  assign m.m_parity = head[DATA_W];
`else
  assign push_data  = {inflight_last_q, ram_do};
`endif

  bram_reader_skid #(.ENTRY_W(ENTRY_W)) u_skid (
    .clk       (CLKA),
    .rst       (RSTB),
    .push      (inflight_q),
    .pop       (pop),
    .push_data (push_data),
    .head      (head),
    .cnt       (fifo_cnt)
  );

  assign m.m_valid = (fifo_cnt != 2'd0);
  assign m.m_data  = head[DATA_W-1:0];
  assign m.m_last  = head[ENTRY_W-1];
  assign ram_en    = issue;
  assign ram_addr  = addr_q;
  assign ram_we    = 1'b0;
  assign ram_rst   = 1'b0;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule
